up_control_unit: RTL and testbench

- Moore/Mealy control FSM that sequences the 8-bit accumulator microprocessor datapath (PC, IR, A register, 32x8 memory) through fetch, decode and execute.
- Drives every datapath control strobe and the Halt output.
- Performs the Enter/Input handshake so that one keypress loads exactly one byte.
- Sits inside uP, between the datapath status signals (IR opcode, Aeq0, Apos) and the datapath control inputs.

---
 rtl/up_control_unit.sv | 140 ++++++++++++++
 tb/tb_up_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/up_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : up_control_unit
// Brief    : Fetch/decode/execute sequencer for the 8-bit accumulator uP,
//            including the Enter/Input one-byte-per-keypress handshake.
// Revision : 1.0 - initial release
// ============================================================================
module up_control_unit #(
    parameter bit ENTER_EDGE = 1'b1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       Enter,
    input  logic [2:0] IR_op,
    input  logic       Aeq0,
    input  logic       Apos,
    output logic       IRload,
    output logic       PCload,
    output logic       JMPmux,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t state;
    state_t next_state;
    logic   enter_q;
    logic   accept;

    // enter_q resets high so an Enter already held at reset release is ignored
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= S_START;
            enter_q <= 1'b1;
        end else begin
            state   <= next_state;
            enter_q <= Enter;
        end
    end

    generate
        if (ENTER_EDGE) begin : g_enter_edge
            assign accept = Enter & ~enter_q;
        end else begin : g_enter_level
            assign accept = Enter;
        end
    endgenerate

    always_comb begin
        next_state = state;
        IRload     = 1'b0;
        PCload     = 1'b0;
        JMPmux     = 1'b0;
        Meminst    = 1'b0;
        MemWr      = 1'b0;
        Asel       = 2'b00;
        Aload      = 1'b0;
        Sub        = 1'b0;
        Halt       = 1'b0;
        case (state)
            S_START: next_state = S_FETCH;
            S_FETCH: begin
                IRload     = 1'b1;
                PCload     = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                Meminst    = 1'b1;
                next_state = state_t'({1'b1, IR_op});
            end
            S_LOAD: begin
                Meminst    = 1'b1;
                Asel       = 2'b10;
                Aload      = 1'b1;
                next_state = S_START;
            end
            S_STORE: begin
                Meminst    = 1'b1;
                MemWr      = 1'b1;
                next_state = S_START;
            end
            S_ADD: begin
                Meminst    = 1'b1;
                Aload      = 1'b1;
                next_state = S_START;
            end
            S_SUB: begin
                Meminst    = 1'b1;
                Aload      = 1'b1;
                Sub        = 1'b1;
                next_state = S_START;
            end
            S_INPUT: begin
                Asel  = 2'b01;
                Aload = accept;
                if (accept) begin
                    next_state = S_START;
                end
            end
            // Conditional jumps are Mealy: PCload follows the live A status
            S_JZ: begin
                JMPmux     = 1'b1;
                PCload     = Aeq0;
                next_state = S_START;
            end
            S_JPOS: begin
                JMPmux     = 1'b1;
                PCload     = Apos;
                next_state = S_START;
            end
            S_HALT: begin
                Halt       = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_START;
        endcase
    end

    assign State = state;

endmodule
`default_nettype wire

// File: tb/tb_up_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_control_unit
// Brief    : Table-driven, scoreboard-checked bench for up_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_control_unit;

    logic       CLOCK;
    logic       RESET;
    logic       Enter;
    logic [2:0] IR_op;
    logic       Aeq0;
    logic       Apos;
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [3:0] State;

    up_control_unit #(.ENTER_EDGE(1'b1)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .Enter  (Enter),
        .IR_op  (IR_op),
        .Aeq0   (Aeq0),
        .Apos   (Apos),
        .IRload (IRload),
        .PCload (PCload),
        .JMPmux (JMPmux),
        .Meminst(Meminst),
        .MemWr  (MemWr),
        .Asel   (Asel),
        .Aload  (Aload),
        .Sub    (Sub),
        .Halt   (Halt),
        .State  (State)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // ctl = {IRload, PCload, JMPmux, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt}
    localparam logic [9:0] C_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] C_FETCH = 10'b11_0000_0000;
    localparam logic [9:0] C_DEC   = 10'b00_0100_0000;
    localparam logic [9:0] C_LOAD  = 10'b00_0101_0100;
    localparam logic [9:0] C_STORE = 10'b00_0110_0000;
    localparam logic [9:0] C_ADD   = 10'b00_0100_0100;
    localparam logic [9:0] C_SUB   = 10'b00_0100_0110;
    localparam logic [9:0] C_INW   = 10'b00_0000_1000;
    localparam logic [9:0] C_INA   = 10'b00_0000_1100;
    localparam logic [9:0] C_JMP0  = 10'b00_1000_0000;
    localparam logic [9:0] C_JMP1  = 10'b01_1000_0000;
    localparam logic [9:0] C_HALT  = 10'b00_0000_0001;

    typedef struct {
        logic       rst;
        logic       enter;
        logic [2:0] op;
        logic       aeq0;
        logic       apos;
        logic [3:0] st;
        logic [9:0] ctl;
    } vec_t;

    vec_t        vecs[$];
    logic [13:0] exp_q[$];
    int          checks;
    int          fails;

    task automatic add(input logic rst, input logic en, input logic [2:0] op,
                       input logic a0, input logic ap,
                       input logic [3:0] st, input logic [9:0] ctl);
        vec_t v;
        v.rst = rst; v.enter = en; v.op = op; v.aeq0 = a0; v.apos = ap;
        v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    // One non-INPUT instruction from START through its execute state
    task automatic instr(input logic [2:0] op, input logic a0, input logic ap,
                         input logic [3:0] st, input logic [9:0] ctl);
        add(1'b0, 1'b0, op, a0, ap, 4'd0, C_NONE);
        add(1'b0, 1'b0, op, a0, ap, 4'd1, C_FETCH);
        add(1'b0, 1'b0, op, a0, ap, 4'd2, C_DEC);
        add(1'b0, 1'b0, op, a0, ap, st,   ctl);
    endtask

    initial begin
        logic [13:0] exp_v;
        logic [9:0]  got_ctl;
        checks = 0;
        fails  = 0;
        RESET  = 1'b1;
        Enter  = 1'b0;
        IR_op  = 3'd0;
        Aeq0   = 1'b0;
        Apos   = 1'b0;

        // Single-cycle instructions; ADD/SUB run with A flags high to show no PC load
        instr(3'd0, 1'b0, 1'b0, 4'd8,  C_LOAD);
        instr(3'd1, 1'b0, 1'b0, 4'd9,  C_STORE);
        instr(3'd2, 1'b1, 1'b1, 4'd10, C_ADD);
        instr(3'd3, 1'b1, 1'b1, 4'd11, C_SUB);
        instr(3'd5, 1'b1, 1'b0, 4'd13, C_JMP1);
        instr(3'd5, 1'b0, 1'b1, 4'd13, C_JMP0);
        instr(3'd6, 1'b0, 1'b1, 4'd14, C_JMP1);
        instr(3'd6, 1'b0, 1'b0, 4'd14, C_JMP0);

        // INPUT: wait 3 cycles, accept on edge, then a held Enter is not re-accepted
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd2,  C_DEC);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INA);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd2,  C_DEC);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INA);

        // Reset in DECODE, then a clean LOAD
        add(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2,  C_DEC);
        instr(3'd0, 1'b0, 1'b0, 4'd8, C_LOAD);

        // Reset while waiting in INPUT, Enter high across reset release
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd2,  C_DEC);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd2,  C_DEC);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 4'd12, C_INW);
        add(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'd12, C_INA);

        // HALT ignores Enter until a one-clock reset
        add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 4'd1,  C_FETCH);
        add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 4'd2,  C_DEC);
        for (int k = 0; k < 22; k++) begin
            add(1'b0, k[0], 3'd7, 1'b1, 1'b1, 4'd15, C_HALT);
        end
        add(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 4'd15, C_HALT);
        add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 4'd0,  C_NONE);
        add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 4'd1,  C_FETCH);

        repeat (2) @(posedge CLOCK);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLOCK);
            RESET = vecs[i].rst;
            Enter = vecs[i].enter;
            IR_op = vecs[i].op;
            Aeq0  = vecs[i].aeq0;
            Apos  = vecs[i].apos;
            exp_q.push_back({vecs[i].st, vecs[i].ctl});
            #2;
            exp_v   = exp_q.pop_front();
            got_ctl = {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt};
            checks++;
            if (State !== exp_v[13:10]) begin
                fails++;
                $display("FAIL row %0d state: got %0d expected %0d", i, State, exp_v[13:10]);
            end
            checks++;
            if (got_ctl !== exp_v[9:0]) begin
                fails++;
                $display("FAIL row %0d ctl (state %0d): got %b expected %b",
                         i, State, got_ctl, exp_v[9:0]);
            end
            checks++;
            if ((MemWr & Aload) !== 1'b0) begin
                fails++;
                $display("FAIL row %0d memwr_aload_overlap: got %b expected 0", i, MemWr & Aload);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
